alu_vec_pipe: RTL and testbench

ALU_VEC_PIPE -- requirements
Module: alu_vec_pipe

---
 rtl/alu_vec_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_vec_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_pipe.sv
// Two-stage SIMD fixed-point ALU with valid/ready flow control.
// S1 captures operands (with optional scalar broadcast); S2 holds per-lane results and NZCV flags.
module alu_vec_pipe #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned FRAC   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    input  logic [2:0]              opcode,
    input  logic                    flag_scalar,
    input  logic                    sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] result,
    output logic [4*LANES-1:0]      flags
);
    localparam int unsigned W   = LANE_W;
    localparam int unsigned VW  = LANES * LANE_W;
    localparam int unsigned SHW = $clog2(LANE_W);

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpShl, OpAsr
    } op_e;

    logic              s1_valid_q, s2_valid_q;
    logic              s1_adv, s2_adv;
    logic [VW-1:0]     a_q, b_q, b_bc;
    op_e               op_q;
    logic              sat_q;
    logic [VW-1:0]     res_q, res_d;
    logic [4*LANES-1:0] flags_q, flags_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign flags     = flags_q;

    always_comb begin
        b_bc = b;
        if (flag_scalar) b_bc = {LANES{b[W-1:0]}};
    end

    // Returns {result, N, Z, C, V} for one lane.
    function automatic logic [W+3:0] lane_op(input logic [W-1:0] la, input logic [W-1:0] lb,
                                             input op_e op, input logic ls);
        logic [W:0]              ext;
        logic [W:0]              sh_l;
        logic signed [W:0]       sh_r;
        logic signed [2*W-1:0]   prod;
        logic signed [2*W-1:0]   prod_sh;
        logic signed [2*W-1:0]   hi;
        logic [SHW-1:0]          amt;
        logic [W-1:0]            r;
        logic                    c, v, neg;
        ext     = '0;
        sh_l    = '0;
        sh_r    = '0;
        prod    = '0;
        prod_sh = '0;
        hi      = '0;
        amt     = lb[SHW-1:0];
        r       = '0;
        c       = 1'b0;
        v       = 1'b0;
        neg     = 1'b0;
        unique case (op)
            OpAdd: begin
                ext = {1'b0, la} + {1'b0, lb};
                r   = ext[W-1:0];
                c   = ext[W];
                v   = (la[W-1] == lb[W-1]) && (r[W-1] != la[W-1]);
                neg = la[W-1];
            end
            OpSub: begin
                ext = {1'b0, la} - {1'b0, lb};
                r   = ext[W-1:0];
                c   = ext[W];
                v   = (la[W-1] != lb[W-1]) && (r[W-1] != la[W-1]);
                neg = la[W-1];
            end
            OpMul: begin
                prod    = $signed({{W{la[W-1]}}, la}) * $signed({{W{lb[W-1]}}, lb});
                prod_sh = prod >>> FRAC;
                r       = prod_sh[W-1:0];
                // Everything above the kept lane must be a sign extension of it.
                hi      = prod_sh >>> (W - 1);
                v       = (hi != '0) && (hi != '1);
                neg     = prod_sh[2*W-1];
            end
            OpAnd: r = la & lb;
            OpOr:  r = la | lb;
            OpXor: r = la ^ lb;
            OpShl: begin
                sh_l = {1'b0, la} << amt;
                r    = sh_l[W-1:0];
                c    = sh_l[W];
            end
            OpAsr: begin
                // Extra LSB catches the last bit shifted out.
                sh_r = $signed({la, 1'b0}) >>> amt;
                r    = sh_r[W:1];
                c    = sh_r[0];
            end
        endcase
        if (ls && v) r = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        for (int i = 0; i < LANES; i++) begin
            {res_d[i*W +: W], flags_d[4*i +: 4]} = lane_op(a_q[i*W +: W], b_q[i*W +: W], op_q,
                                                          sat_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OpAdd;
            sat_q      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b_bc;
                op_q  <= op_e'(opcode);
                sat_q <= sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_vec_pipe.sv
// Randomized and directed bench for alu_vec_pipe against an integer-arithmetic lane model.
module tb_alu_vec_pipe;
    localparam int LANES = 16;
    localparam int W     = 16;
    localparam int VW    = LANES * W;
    localparam int FW    = 4 * LANES;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [VW-1:0]  a;
    logic [VW-1:0]  b;
    logic [2:0]     opcode;
    logic           flag_scalar;
    logic           sat;
    logic           out_valid;
    logic           out_ready;
    logic [VW-1:0]  result;
    logic [FW-1:0]  flags;

    alu_vec_pipe #(.LANES(LANES), .LANE_W(W), .FRAC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .flag_scalar(flag_scalar),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] res;
        logic [FW-1:0] flg;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_pass      = 0;
    int   n_total     = 0;
    int   cycle       = 0;
    int   checked_acc = -1;
    int   n_out       = 0;

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [VW-1:0] rep(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [FW-1:0] repf(input logic [3:0] v);
        return {LANES{v}};
    endfunction

    // One lane computed on plain integers: unsigned/signed views of the operands.
    function automatic void model_lane(input int op, input bit st, input int ua, input int ub,
                                       output int r, output logic [3:0] f);
        int     sa, sb, n;
        longint t;
        bit     c, v;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        n  = ub % 16;
        c  = 0;
        v  = 0;
        t  = 0;
        r  = 0;
        case (op)
            0: begin
                t = longint'(sa) + longint'(sb);
                r = ua + ub;
                c = (r > 65535);
                v = (t > 32767) || (t < -32768);
            end
            1: begin
                t = longint'(sa) - longint'(sb);
                r = ua - ub;
                c = (ua < ub);
                v = (t > 32767) || (t < -32768);
            end
            2: begin
                t = (longint'(sa) * longint'(sb)) >>> 8;
                r = int'(t & 64'hFFFF);
                v = (t > 32767) || (t < -32768);
            end
            3: r = ua & ub;
            4: r = ua | ub;
            5: r = ua ^ ub;
            6: begin
                r = ua << n;
                c = (n != 0) && (((ua >> (16 - n)) & 1) != 0);
            end
            default: begin
                r = sa >>> n;
                c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
            end
        endcase
        if (st && v && op <= 2) r = (t > 0) ? 32'h7FFF : 32'h8000;
        r = r & 32'hFFFF;
        f = {r[15], (r == 0), c, v};
    endfunction

    function automatic exp_t model(input logic [VW-1:0] ta, input logic [VW-1:0] tb_,
                                   input logic [2:0] op, input logic fs, input logic st);
        exp_t       e;
        int         r;
        logic [3:0] f;
        e.acc = 0;
        e.res = '0;
        e.flg = '0;
        for (int i = 0; i < LANES; i++) begin
            model_lane(int'(op), st, int'(ta[i*W +: W]),
                       int'(fs ? tb_[W-1:0] : tb_[i*W +: W]), r, f);
            e.res[i*W +: W] = r[15:0];
            e.flg[4*i +: 4] = f;
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [15:0]   corners[8];
        corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h0100, 16'hFF00,
                    16'h7F00};
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 3) == 0) v[i*W +: W] = corners[$urandom_range(0, 7)];
            else v[i*W +: W] = 16'($urandom);
        end
        return v;
    endfunction

    // Scoreboard: push on accept, pop on completion.
    always @(posedge clk) begin
        exp_t e;
        cycle++;
        if (!rst) begin
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                n_out++;
            end
            if (in_valid && in_ready) begin
                e     = model(a, b, opcode, flag_scalar, sat);
                e.acc = cycle;
                q.push_back(e);
            end
        end
    end

    // Compare process: every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_output: got out_valid=1 expected no pending bundle");
            end else begin
                check("result", result, q[0].res);
                check("flags", VW'(flags), VW'(q[0].flg));
                if (q[0].acc != checked_acc) begin
                    checked_acc = q[0].acc;
                    check("latency_min", VW'((cycle + 1 - q[0].acc) >= 2), VW'(1));
                end
            end
        end
    end

    task automatic send(input logic [VW-1:0] ta, input logic [VW-1:0] tb_, input logic [2:0] op,
                        input logic fs, input logic st);
        bit done;
        done        = 0;
        a           = ta;
        b           = tb_;
        opcode      = op;
        flag_scalar = fs;
        sat         = st;
        in_valid    = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) done = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic run_one(input string nm, input logic [VW-1:0] ta, input logic [VW-1:0] tb_,
                           input logic [2:0] op, input logic fs, input logic st,
                           input logic [VW-1:0] er, input logic [FW-1:0] ef);
        out_ready = 1'b1;
        send(ta, tb_, op, fs, st);
        check({nm, "_not_yet"}, VW'(out_valid), VW'(0));
        @(negedge clk);
        check({nm, "_valid"}, VW'(out_valid), VW'(1));
        check({nm, "_res"}, result, er);
        check({nm, "_flg"}, VW'(flags), VW'(ef));
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok;
        ok        = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) ok = 1;
        end
        check("drain_empty", VW'(ok), VW'(1));
    endtask

    initial begin
        exp_t          m;
        logic [VW-1:0] bv;
        int            n0;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
        flag_scalar = 1'b0; sat = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_result", result, '0);
        check("rst_flags", VW'(flags), VW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Pin the model with hand-computed lanes.
        m = model(rep(16'h0180), rep(16'hFE40), 3'd2, 1'b0, 1'b0);
        check("model_mul", m.res, rep(16'hFD60));
        check("model_mul_flg", VW'(m.flg), VW'(repf(4'b1000)));
        m = model(rep(16'h7F00), rep(16'h0200), 3'd0, 1'b0, 1'b1);
        check("model_add_sat", m.res, rep(16'h7FFF));
        check("model_add_sat_flg", VW'(m.flg), VW'(repf(4'b0001)));

        run_one("mul", rep(16'h0180), rep(16'hFE40), 3'd2, 1'b0, 1'b0, rep(16'hFD60),
                repf(4'b1000));
        bv = rep(16'h1234);
        bv[15:0] = 16'h0200;
        run_one("mul_scalar", rep(16'h0180), bv, 3'd2, 1'b1, 1'b0, rep(16'h0300), repf(4'b0000));
        run_one("add_wrap", rep(16'h7F00), rep(16'h0200), 3'd0, 1'b0, 1'b0, rep(16'h8100),
                repf(4'b1001));
        run_one("add_sat", rep(16'h7F00), rep(16'h0200), 3'd0, 1'b0, 1'b1, rep(16'h7FFF),
                repf(4'b0001));
        run_one("asr", rep(16'h8000), rep(16'h0001), 3'd7, 1'b0, 1'b0, rep(16'hC000),
                repf(4'b1000));
        run_one("sub_borrow", rep(16'h0001), rep(16'h0002), 3'd1, 1'b0, 1'b0, rep(16'hFFFF),
                repf(4'b1010));

        // Backpressure: three bundles against a stalled consumer.
        n0 = n_out;
        out_ready = 1'b0;
        a = rep(16'h0001); b = rep(16'h0001); opcode = 3'd0; flag_scalar = 1'b0; sat = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready1", VW'(in_ready), VW'(1));
        a = rep(16'h0003);
        @(negedge clk);
        a = rep(16'h0005);
        for (int k = 0; k < 3; k++) begin
            check("bp_ready_low", VW'(in_ready), VW'(0));
            check("bp_hold", result, rep(16'h0002));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second", result, rep(16'h0004));
        @(negedge clk);
        check("bp_third", result, rep(16'h0006));
        drain();
        check("bp_count", VW'(n_out - n0), VW'(3));

        // Reset with both stages full.
        out_ready = 1'b0;
        send(rep(16'h1111), rep(16'h0101), 3'd5, 1'b0, 1'b0);
        send(rep(16'h2222), rep(16'h0101), 3'd4, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", VW'(out_valid), VW'(0));
        check("mid_rst_result", result, '0);
        check("mid_rst_flags", VW'(flags), VW'(0));
        check("mid_rst_in_ready", VW'(in_ready), VW'(1));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_one("post_rst_shl", rep(16'h4001), rep(16'h0002), 3'd6, 1'b0, 1'b0, rep(16'h0004),
                repf(4'b0010));
        drain();

        // Continuous stream: one result per cycle.
        n0 = n_out;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a = rand_vec(); b = rand_vec(); opcode = 3'($urandom_range(0, 7));
            flag_scalar = ($urandom_range(0, 3) == 0); sat = 1'($urandom_range(0, 1));
            check("stream_ready", VW'(in_ready), VW'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stream_count", VW'(n_out - n0), VW'(20));

        // Random traffic with random backpressure.
        for (int k = 0; k < 1500; k++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            opcode      = 3'($urandom_range(0, 7));
            flag_scalar = ($urandom_range(0, 3) == 0);
            sat         = 1'($urandom_range(0, 1));
            a           = rand_vec();
            b           = rand_vec();
            @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
